// File: rtl/spart_tx_mmio.sv
// spart_tx_mmio: memory-mapped 8N1 serial transmitter.
// Stores to BASE_ADDR are queued in a small FIFO and shifted out LSB first
// on txd. The status register at BASE_ADDR+1 is readable on the same bus.
// A store that finds the FIFO full raises stall until the FIFO has room.
module spart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter logic [15:0] BAUD_DIV   = 16'd434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_mem_addr,
  input  logic [31:0] data_mem_write_data,
  input  logic        data_mem_wr,
  input  logic        data_mem_en,
  output logic [31:0] mmio_read_data,
  output logic        mmio_sel,
  output logic        stall,
  output logic        txd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic            hit_data, hit_stat;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic            baud_last;
  logic [4:0]      count5;
  logic [31:0]     status_word;
  logic            unused_wdata;

  // Only the low byte of the store data is transmitted.
  assign unused_wdata = ^data_mem_write_data[31:8];

  // Address decode and bus-side handshake.
  assign hit_data   = data_mem_en && (data_mem_addr == BASE_ADDR);
  assign hit_stat   = data_mem_en && (data_mem_addr == BASE_ADDR + 32'd1);
  assign mmio_sel   = hit_data || hit_stat;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Stall and push look only at the registered count, so a pop in the same
  // cycle cannot open a combinational path from the FSM back to the bus.
  assign stall = hit_data && data_mem_wr && fifo_full;
  assign push  = hit_data && data_mem_wr && !fifo_full;

  assign count5      = 5'(count_q);
  assign status_word = {23'd0, count5, 1'b0, fifo_full, !fifo_empty,
                        (state_q != S_IDLE)};
  assign mmio_read_data = (hit_stat && !data_mem_wr) ? status_word : 32'd0;

  assign txd       = txd_q;
  assign baud_last = (baud_cnt_q == BAUD_DIV - 16'd1);

  // FIFO storage write port.
  // NOTE: the data array has no reset; the pointers and count alone define
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_mem_write_data[7:0];
  end

  // FIFO pointers and occupancy count.
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its neighbours, regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmitter state register; txd is registered to keep the line glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

  // Transmitter next-state: start bit, 8 data bits LSB first, stop bit.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          baud_cnt_d = '0;
          txd_d      = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          txd_d      = shift_q[0];
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          txd_d      = 1'b1;
          state_d    = S_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spart_tx_mmio.sv
// Directed testbench for spart_tx_mmio with BAUD_DIV=4 and FIFO_DEPTH=4.
module tb_spart_tx_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] STAT = 32'hFFFF_FF01;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_mem_addr;
  logic [31:0] data_mem_write_data;
  logic        data_mem_wr;
  logic        data_mem_en;
  logic [31:0] mmio_read_data;
  logic        mmio_sel;
  logic        stall;
  logic        txd;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  bit txd_log [4096];

  spart_tx_mmio #(
    .BASE_ADDR (BASE),
    .BAUD_DIV  (16'd4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .data_mem_addr      (data_mem_addr),
    .data_mem_write_data(data_mem_write_data),
    .data_mem_wr        (data_mem_wr),
    .data_mem_en        (data_mem_en),
    .mmio_read_data     (mmio_read_data),
    .mmio_sel           (mmio_sel),
    .stall              (stall),
    .txd                (txd)
  );

  always #5 clk = ~clk;

  // Record the serial line once per cycle, mid-cycle.
  always @(negedge clk) begin
    if (cyc < 4096) txd_log[cyc] = txd;
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic en, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata);
    data_mem_en         = en;
    data_mem_wr         = wr;
    data_mem_addr       = addr;
    data_mem_write_data = wdata;
    #1;
  endtask

  initial begin
    int n, s, bad, t3_start, found;
    logic [7:0] b;
    logic e;

    rst = 1'b1;
    data_mem_en = 1'b0; data_mem_wr = 1'b0;
    data_mem_addr = '0; data_mem_write_data = '0;

    // ---- Reset and idle ----
    repeat (3) tick();
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_sel_idle_bus", 32'(mmio_sel), 32'd0);
    rst = 1'b0;
    bus(1'b1, 1'b0, STAT, 32'd0);
    chk("idle_sel_stat", 32'(mmio_sel), 32'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (txd !== 1'b1 || stall !== 1'b0 || mmio_read_data !== 32'd0) bad++;
      tick();
    end
    chk("idle_50_cycles_bad", 32'(bad), 32'd0);

    // ---- Single byte 0xA5 ----
    bus(1'b1, 1'b1, BASE, 32'hFFFF_FFA5);
    chk("a5_sel", 32'(mmio_sel), 32'd1);
    chk("a5_no_stall", 32'(stall), 32'd0);
    tick();
    bus(1'b1, 1'b0, STAT, 32'd0);
    chk("a5_push_edge_txd", 32'(txd), 32'd1);
    chk("a5_queued_status", mmio_read_data, 32'h0000_0012);
    tick();
    b = 8'hA5;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      e = (i < 4) ? 1'b0 : (i < 36) ? b[(i - 4) / 4] : 1'b1;
      if (txd !== e) bad++;
      if (mmio_read_data !== 32'h0000_0001) bad++;
      tick();
    end
    chk("a5_frame_bad", 32'(bad), 32'd0);
    chk("a5_done_status", mmio_read_data, 32'd0);
    chk("a5_done_txd", 32'(txd), 32'd1);

    // ---- Fill and stall: 0x01..0x06 back to back ----
    repeat (5) tick();
    t3_start = cyc;
    for (int k = 1; k <= 5; k++) begin
      bus(1'b1, 1'b1, BASE, 32'(k));
      chk("fill_no_stall", 32'(stall), 32'd0);
      tick();
    end
    bus(1'b1, 1'b1, BASE, 32'd6);
    chk("fill_6th_stall", 32'(stall), 32'd1);
    // A store elsewhere never stalls, even with the FIFO full.
    bus(1'b1, 1'b1, BASE + 32'd2, 32'd6);
    chk("full_other_addr_no_stall", 32'(stall), 32'd0);
    bus(1'b1, 1'b1, BASE, 32'd6);
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("stall_cycles", 32'(n), 32'd38);
    chk("stall_released", 32'(stall), 32'd0);
    tick();
    bus(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (290) tick();

    found = 0; s = 0;
    for (int i = t3_start; i < t3_start + 100; i++) begin
      if (found == 0 && txd_log[i] == 1'b0) begin
        s = i;
        found = 1;
      end
    end
    chk("fill_start_found", 32'(found), 32'd1);
    chk("fill_first_start", 32'(s), 32'(t3_start + 2));
    for (int k = 0; k < 6; k++) begin
      b = 8'(k + 1);
      bad = 0;
      for (int i = 0; i < 41; i++) begin
        e = (i < 4) ? 1'b0 : (i < 36) ? b[(i - 4) / 4] : 1'b1;
        if (txd_log[s + 41 * k + i] !== e) bad++;
      end
      chk($sformatf("fill_frame_%0d_bad", k + 1), 32'(bad), 32'd0);
    end
    bad = 0;
    for (int i = 0; i < 30; i++)
      if (txd_log[s + 246 + i] !== 1'b1) bad++;
    chk("fill_no_extra_frame", 32'(bad), 32'd0);

    // ---- Status readout with frame in flight ----
    bus(1'b1, 1'b1, BASE, 32'h11); tick();
    bus(1'b1, 1'b1, BASE, 32'h22); tick();
    bus(1'b1, 1'b1, BASE, 32'h33); tick();
    bus(1'b1, 1'b0, STAT, 32'd0);
    chk("status_inflight", mmio_read_data, 32'h0000_0023);
    // Stores to the status register are ignored.
    bus(1'b1, 1'b1, STAT, 32'hFF);
    chk("status_store_rdata", mmio_read_data, 32'd0);
    tick();
    bus(1'b1, 1'b0, STAT, 32'd0);
    chk("status_after_stat_store", mmio_read_data, 32'h0000_0023);
    bus(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (140) tick();
    bus(1'b1, 1'b0, STAT, 32'd0);
    chk("status_drained", mmio_read_data, 32'd0);

    // ---- Decode isolation ----
    bus(1'b1, 1'b1, BASE + 32'd2, 32'h55);
    chk("iso_st_p2_sel", 32'(mmio_sel), 32'd0);
    chk("iso_st_p2_stall", 32'(stall), 32'd0);
    tick();
    bus(1'b1, 1'b0, BASE + 32'd2, 32'd0);
    chk("iso_ld_p2_sel", 32'(mmio_sel), 32'd0);
    chk("iso_ld_p2_rdata", mmio_read_data, 32'd0);
    tick();
    bus(1'b1, 1'b1, 32'd0, 32'h66);
    chk("iso_st_0_sel", 32'(mmio_sel), 32'd0);
    tick();
    bus(1'b1, 1'b0, 32'd0, 32'd0);
    chk("iso_ld_0_rdata", mmio_read_data, 32'd0);
    tick();
    bus(1'b1, 1'b0, BASE, 32'd0);
    chk("iso_ld_base_sel", 32'(mmio_sel), 32'd1);
    chk("iso_ld_base_rdata", mmio_read_data, 32'd0);
    tick();
    bus(1'b1, 1'b0, STAT, 32'd0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (txd !== 1'b1 || mmio_read_data !== 32'd0) bad++;
      tick();
    end
    chk("iso_no_fifo_change", 32'(bad), 32'd0);

    // ---- Reset mid-frame ----
    bus(1'b1, 1'b1, BASE, 32'h3C); tick();
    bus(1'b1, 1'b1, BASE, 32'hA1); tick();
    bus(1'b1, 1'b1, BASE, 32'hA2); tick();
    bus(1'b1, 1'b0, STAT, 32'd0);
    repeat (16) tick();
    // Now in data bit 3 of 0x3C with two bytes queued.
    chk("rstmid_pre_status", mmio_read_data, 32'h0000_0023);
    chk("rstmid_pre_txd_bit3", 32'(txd), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstmid_txd_at_reset", 32'(txd), 32'd1);
    chk("rstmid_status_at_reset", mmio_read_data, 32'd0);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1 || mmio_read_data !== 32'd0) bad++;
      tick();
    end
    chk("rstmid_quiet_after", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
